// File: rtl/kanagawa_fifo_debug_monitor.sv
// Debug monitor for a bank of same-clock FIFOs: sticky overflow/underflow flags,
// saturating error counters, shadow occupancy with high-watermark, first-error capture.
module kanagawa_fifo_debug_monitor #(
    parameter int NUM_CHANNELS = 4,
    parameter int DEPTH        = 32,
    parameter int COUNT_WIDTH  = 8,
    localparam int OCC_WIDTH   = $clog2(DEPTH + 1),
    localparam int SEL_WIDTH   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CHANNELS-1:0] full_in,
    input  logic [NUM_CHANNELS-1:0] wren_in,
    input  logic [NUM_CHANNELS-1:0] empty_in,
    input  logic [NUM_CHANNELS-1:0] rden_in,
    input  logic                    clear_in,
    input  logic [SEL_WIDTH-1:0]    sel_in,
    output logic [NUM_CHANNELS-1:0] overflow_out,
    output logic [NUM_CHANNELS-1:0] underflow_out,
    output logic                    error_out,
    output logic                    first_err_valid_out,
    output logic [SEL_WIDTH-1:0]    first_err_chan_out,
    output logic                    first_err_is_underflow_out,
    output logic [COUNT_WIDTH-1:0]  sel_err_count_out,
    output logic [OCC_WIDTH-1:0]    sel_occupancy_out,
    output logic [OCC_WIDTH-1:0]    sel_watermark_out
);

    localparam logic [OCC_WIDTH-1:0] OCC_MAX = OCC_WIDTH'(DEPTH);

    logic [NUM_CHANNELS-1:0] ovf_ev, unf_ev, wr_acc, rd_acc;
    logic [NUM_CHANNELS-1:0] ovf_q, unf_q, ovf_d, unf_d;
    logic                    error_q;

    logic [COUNT_WIDTH-1:0]  count_q   [NUM_CHANNELS];
    logic [COUNT_WIDTH-1:0]  count_d   [NUM_CHANNELS];
    logic [COUNT_WIDTH:0]    count_sum [NUM_CHANNELS];
    logic [OCC_WIDTH-1:0]    occ_q     [NUM_CHANNELS];
    logic [OCC_WIDTH-1:0]    occ_d     [NUM_CHANNELS];
    logic [OCC_WIDTH-1:0]    wm_q      [NUM_CHANNELS];
    logic [OCC_WIDTH-1:0]    wm_d      [NUM_CHANNELS];

    logic                    valid_q, valid_d;
    logic [SEL_WIDTH-1:0]    chan_q, chan_d;
    logic                    is_unf_q, is_unf_d;
    logic                    any_ev;
    logic [SEL_WIDTH-1:0]    hit_chan;
    logic                    hit_unf;

    logic [COUNT_WIDTH-1:0]  sel_count_q, sel_count_d;
    logic [OCC_WIDTH-1:0]    sel_occ_q, sel_occ_d;
    logic [OCC_WIDTH-1:0]    sel_wm_q, sel_wm_d;

    assign ovf_ev = wren_in & full_in;
    assign unf_ev = rden_in & empty_in;
    assign wr_acc = wren_in & ~full_in;
    assign rd_acc = rden_in & ~empty_in;

    // clear_in wipes the previous state, then same-cycle events are applied on top
    always_comb begin
        ovf_d = (clear_in ? '0 : ovf_q) | ovf_ev;
        unf_d = (clear_in ? '0 : unf_q) | unf_ev;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            count_sum[i] = {1'b0, (clear_in ? {COUNT_WIDTH{1'b0}} : count_q[i])}
                         + {{COUNT_WIDTH{1'b0}}, ovf_ev[i]}
                         + {{COUNT_WIDTH{1'b0}}, unf_ev[i]};
            count_d[i]   = count_sum[i][COUNT_WIDTH] ? '1 : count_sum[i][COUNT_WIDTH-1:0];

            occ_d[i] = occ_q[i];
            if (wr_acc[i] && !rd_acc[i] && occ_q[i] != OCC_MAX)
                occ_d[i] = occ_q[i] + OCC_WIDTH'(1);
            else if (rd_acc[i] && !wr_acc[i] && occ_q[i] != '0)
                occ_d[i] = occ_q[i] - OCC_WIDTH'(1);

            if (clear_in || occ_d[i] > wm_q[i])
                wm_d[i] = occ_d[i];
            else
                wm_d[i] = wm_q[i];
        end
    end

    // Descending scan so the lowest-index channel with an event wins
    always_comb begin
        any_ev   = |(ovf_ev | unf_ev);
        hit_chan = '0;
        hit_unf  = 1'b0;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            if (ovf_ev[i] || unf_ev[i]) begin
                hit_chan = SEL_WIDTH'(i);
                hit_unf  = !ovf_ev[i];
            end
        end

        valid_d  = valid_q;
        chan_d   = chan_q;
        is_unf_d = is_unf_q;
        if (clear_in) begin
            valid_d  = 1'b0;
            chan_d   = '0;
            is_unf_d = 1'b0;
        end
        if ((clear_in || !valid_q) && any_ev) begin
            valid_d  = 1'b1;
            chan_d   = hit_chan;
            is_unf_d = hit_unf;
        end
    end

    // Readout reflects the post-update state of the selected channel
    always_comb begin
        sel_count_d = '0;
        sel_occ_d   = '0;
        sel_wm_d    = '0;
        if (int'(sel_in) < NUM_CHANNELS) begin
            sel_count_d = count_d[sel_in];
            sel_occ_d   = occ_d[sel_in];
            sel_wm_d    = wm_d[sel_in];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q       <= '0;
            unf_q       <= '0;
            error_q     <= 1'b0;
            valid_q     <= 1'b0;
            chan_q      <= '0;
            is_unf_q    <= 1'b0;
            sel_count_q <= '0;
            sel_occ_q   <= '0;
            sel_wm_q    <= '0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                count_q[i] <= '0;
                occ_q[i]   <= '0;
                wm_q[i]    <= '0;
            end
        end else begin
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            error_q     <= (|ovf_d) | (|unf_d);
            valid_q     <= valid_d;
            chan_q      <= chan_d;
            is_unf_q    <= is_unf_d;
            sel_count_q <= sel_count_d;
            sel_occ_q   <= sel_occ_d;
            sel_wm_q    <= sel_wm_d;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                count_q[i] <= count_d[i];
                occ_q[i]   <= occ_d[i];
                wm_q[i]    <= wm_d[i];
            end
        end
    end

    assign overflow_out               = ovf_q;
    assign underflow_out              = unf_q;
    assign error_out                  = error_q;
    assign first_err_valid_out        = valid_q;
    assign first_err_chan_out         = chan_q;
    assign first_err_is_underflow_out = is_unf_q;
    assign sel_err_count_out          = sel_count_q;
    assign sel_occupancy_out          = sel_occ_q;
    assign sel_watermark_out          = sel_wm_q;

endmodule

// File: tb/tb_kanagawa_fifo_debug_monitor.sv
// Directed bench for kanagawa_fifo_debug_monitor: expectations queued as stimulus
// is applied, then popped and checked against the registered outputs.
module tb_kanagawa_fifo_debug_monitor;

    localparam int K_OVF   = 0;
    localparam int K_UNF   = 1;
    localparam int K_ERR   = 2;
    localparam int K_VALID = 3;
    localparam int K_CHAN  = 4;
    localparam int K_ISUNF = 5;
    localparam int K_CNT   = 6;
    localparam int K_OCC   = 7;
    localparam int K_WM    = 8;
    localparam int K5_CNT  = 9;
    localparam int K5_OCC  = 10;
    localparam int K5_WM   = 11;

    typedef struct {
        string       tag;
        int          kind;
        logic [31:0] value;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] full = '0, wren = '0, empty = '0, rden = '0;
    logic       clear = 1'b0;
    logic [1:0] sel = '0;
    logic [3:0] overflow, underflow;
    logic       error, fe_valid, fe_unf;
    logic [1:0] fe_chan;
    logic [3:0] cnt;
    logic [3:0] occ, wm;

    logic [4:0] full5 = '0, wren5 = '0, empty5 = '0, rden5 = '0;
    logic       clear5 = 1'b0;
    logic [2:0] sel5 = '0;
    logic [4:0] overflow5, underflow5;
    logic       error5, fe_valid5, fe_unf5;
    logic [2:0] fe_chan5;
    logic [3:0] cnt5;
    logic [3:0] occ5, wm5;

    exp_t sb[$];
    int   compared = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    kanagawa_fifo_debug_monitor #(.NUM_CHANNELS(4), .DEPTH(8), .COUNT_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .full_in(full), .wren_in(wren), .empty_in(empty),
        .rden_in(rden), .clear_in(clear), .sel_in(sel), .overflow_out(overflow),
        .underflow_out(underflow), .error_out(error), .first_err_valid_out(fe_valid),
        .first_err_chan_out(fe_chan), .first_err_is_underflow_out(fe_unf),
        .sel_err_count_out(cnt), .sel_occupancy_out(occ), .sel_watermark_out(wm)
    );

    kanagawa_fifo_debug_monitor #(.NUM_CHANNELS(5), .DEPTH(8), .COUNT_WIDTH(4)) dut5 (
        .clk(clk), .rst_n(rst_n), .full_in(full5), .wren_in(wren5), .empty_in(empty5),
        .rden_in(rden5), .clear_in(clear5), .sel_in(sel5), .overflow_out(overflow5),
        .underflow_out(underflow5), .error_out(error5), .first_err_valid_out(fe_valid5),
        .first_err_chan_out(fe_chan5), .first_err_is_underflow_out(fe_unf5),
        .sel_err_count_out(cnt5), .sel_occupancy_out(occ5), .sel_watermark_out(wm5)
    );

    function automatic logic [31:0] observe(input int kind);
        case (kind)
            K_OVF:   return 32'(overflow);
            K_UNF:   return 32'(underflow);
            K_ERR:   return 32'(error);
            K_VALID: return 32'(fe_valid);
            K_CHAN:  return 32'(fe_chan);
            K_ISUNF: return 32'(fe_unf);
            K_CNT:   return 32'(cnt);
            K_OCC:   return 32'(occ);
            K_WM:    return 32'(wm);
            K5_CNT:  return 32'(cnt5);
            K5_OCC:  return 32'(occ5);
            K5_WM:   return 32'(wm5);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic expect_val(input string tag, input int kind, input logic [31:0] v);
        exp_t e;
        e.tag   = tag;
        e.kind  = kind;
        e.value = v;
        sb.push_back(e);
    endtask

    task automatic check_output();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.kind);
            compared++;
            assert (obs === e.value) else begin
                mismatched++;
                $error("[TB] FAIL %s observed=%0h expected=%0h", e.tag, obs, e.value);
            end
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic apply_idle();
        full = '0; wren = '0; empty = '0; rden = '0; clear = 1'b0;
        full5 = '0; wren5 = '0; empty5 = '0; rden5 = '0; clear5 = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tick(2);
        expect_val("rst_ovf", K_OVF, 0);
        expect_val("rst_unf", K_UNF, 0);
        expect_val("rst_err", K_ERR, 0);
        expect_val("rst_valid", K_VALID, 0);
        expect_val("rst_cnt", K_CNT, 0);
        expect_val("rst_occ", K_OCC, 0);
        expect_val("rst_wm", K_WM, 0);
        check_output();
        rst_n = 1'b1;
        tick();

        // Clean write on ch0
        sel = 2'd0; wren = 4'b0001;
        tick(); apply_idle();
        expect_val("w0_ovf", K_OVF, 0);
        expect_val("w0_unf", K_UNF, 0);
        expect_val("w0_err", K_ERR, 0);
        expect_val("w0_valid", K_VALID, 0);
        check_output();
        tick();
        expect_val("w0_occ", K_OCC, 1);
        expect_val("w0_wm", K_WM, 1);
        check_output();

        // Overflow ch2 and underflow ch1 together
        wren = 4'b0100; full = 4'b0100; rden = 4'b0010; empty = 4'b0010;
        tick(); apply_idle();
        expect_val("mix_ovf", K_OVF, 4'b0100);
        expect_val("mix_unf", K_UNF, 4'b0010);
        expect_val("mix_err", K_ERR, 1);
        expect_val("mix_valid", K_VALID, 1);
        expect_val("mix_chan", K_CHAN, 1);
        expect_val("mix_isunf", K_ISUNF, 1);
        check_output();
        sel = 2'd1; tick();
        expect_val("mix_cnt1", K_CNT, 1);
        check_output();

        // 20 overflows on ch3 saturate the 4-bit counter
        sel = 2'd3; wren = 4'b1000; full = 4'b1000;
        tick(20); apply_idle(); tick();
        expect_val("sat_cnt3", K_CNT, 15);
        expect_val("sat_ovf", K_OVF, 4'b1100);
        expect_val("sat_chan", K_CHAN, 1);
        check_output();

        // 10 writes saturate occupancy at DEPTH, then 3 reads
        wren = 4'b1000; tick(10); apply_idle();
        rden = 4'b1000; tick(3); apply_idle(); tick();
        expect_val("occ3", K_OCC, 5);
        expect_val("wm3", K_WM, 8);
        expect_val("occ3_unf", K_UNF, 4'b0010);
        check_output();

        // Reads past empty on ch0 hold occupancy at zero
        sel = 2'd0; rden = 4'b0001; tick(2); apply_idle(); tick();
        expect_val("occ0_floor", K_OCC, 0);
        expect_val("wm0_keep", K_WM, 1);
        check_output();

        // Clear together with an overflow on ch0
        sel = 2'd3; clear = 1'b1; wren = 4'b0001; full = 4'b0001;
        tick(); apply_idle();
        expect_val("clr_ovf", K_OVF, 4'b0001);
        expect_val("clr_unf", K_UNF, 0);
        expect_val("clr_err", K_ERR, 1);
        expect_val("clr_valid", K_VALID, 1);
        expect_val("clr_chan", K_CHAN, 0);
        expect_val("clr_isunf", K_ISUNF, 0);
        check_output();
        tick();
        expect_val("clr_cnt3", K_CNT, 0);
        expect_val("clr_occ3", K_OCC, 5);
        expect_val("clr_wm3", K_WM, 5);
        check_output();
        sel = 2'd0; tick();
        expect_val("clr_cnt0", K_CNT, 1);
        check_output();

        // Plain clear empties the capture, then a double event on ch2
        clear = 1'b1; tick(); apply_idle();
        expect_val("clr2_valid", K_VALID, 0);
        expect_val("clr2_err", K_ERR, 0);
        expect_val("clr2_ovf", K_OVF, 0);
        check_output();
        sel = 2'd2; wren = 4'b0100; full = 4'b0100; rden = 4'b1100; empty = 4'b1100;
        tick(); apply_idle();
        expect_val("dbl_chan", K_CHAN, 2);
        expect_val("dbl_isunf", K_ISUNF, 0);
        expect_val("dbl_ovf", K_OVF, 4'b0100);
        expect_val("dbl_unf", K_UNF, 4'b1100);
        expect_val("dbl_err", K_ERR, 1);
        check_output();
        tick();
        expect_val("dbl_cnt2", K_CNT, 2);
        check_output();

        // Asynchronous reset in the middle of a low phase
        #2 rst_n = 1'b0;
        #1;
        expect_val("arst_ovf", K_OVF, 0);
        expect_val("arst_unf", K_UNF, 0);
        expect_val("arst_err", K_ERR, 0);
        expect_val("arst_valid", K_VALID, 0);
        expect_val("arst_cnt", K_CNT, 0);
        check_output();
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Out-of-range select on a 5-channel build
        sel5 = 3'd4; wren5 = 5'b10000; tick();
        full5 = 5'b10000; tick(); apply_idle(); tick();
        expect_val("ch4_occ", K5_OCC, 1);
        expect_val("ch4_wm", K5_WM, 1);
        expect_val("ch4_cnt", K5_CNT, 1);
        check_output();
        sel5 = 3'd7; tick();
        expect_val("sel7_occ", K5_OCC, 0);
        expect_val("sel7_wm", K5_WM, 0);
        expect_val("sel7_cnt", K5_CNT, 0);
        check_output();
        sel5 = 3'd5; tick();
        expect_val("sel5_occ", K5_OCC, 0);
        expect_val("sel5_cnt", K5_CNT, 0);
        check_output();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
